lru_cache_nway: RTL and testbench

Parametrised, fully associative, true-LRU read cache between a tag-addressed front-end request stream and a slower back-end memory stream in the 250 MHz box. It replaces single-line, simulation-only lookup with a synthesizable request/lookup/refill state machine: valid bits, registered tag compare, ready/valid on all four channels, explicit victim selection and a flush input. One request is in flight at a time.

---
 rtl/lru_cache_nway_if.sv | 46 ++++
 rtl/lru_cache_nway.sv | 239 +++++++++++++++++++++++
 tb/tb_lru_cache_nway.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lru_cache_nway_if.sv
// Channel bundle for lru_cache_nway: front-end request/response and
// back-end memory request/response, all ready/valid.
// slave  = cache side, master = environment side.
interface lru_cache_nway_if #(
    parameter int TAGS_WIDTH = 48,
    parameter int LINE_WIDTH = 512
);
    logic                  req_tvalid;
    logic                  req_tready;
    logic [TAGS_WIDTH-1:0] req_tdata;

    logic                  rsp_tvalid;
    logic                  rsp_tready;
    logic [LINE_WIDTH-1:0] rsp_tdata;
    logic                  rsp_tuser;

    logic                  mem_req_tvalid;
    logic                  mem_req_tready;
    logic [TAGS_WIDTH-1:0] mem_req_tdata;

    logic                  mem_rsp_tvalid;
    logic                  mem_rsp_tready;
    logic [LINE_WIDTH-1:0] mem_rsp_tdata;

    modport slave (
        input  req_tvalid, req_tdata,
        output req_tready,
        output rsp_tvalid, rsp_tdata, rsp_tuser,
        input  rsp_tready,
        output mem_req_tvalid, mem_req_tdata,
        input  mem_req_tready,
        input  mem_rsp_tvalid, mem_rsp_tdata,
        output mem_rsp_tready
    );

    modport master (
        output req_tvalid, req_tdata,
        input  req_tready,
        input  rsp_tvalid, rsp_tdata, rsp_tuser,
        output rsp_tready,
        input  mem_req_tvalid, mem_req_tdata,
        output mem_req_tready,
        output mem_rsp_tvalid, mem_rsp_tdata,
        input  mem_rsp_tready
    );
endinterface

// File: rtl/lru_cache_nway.sv
// Fully associative true-LRU read cache, one request in flight.
// Optional statistics counters enabled by defining LRU_CACHE_STATS_EN;
// without it hit_count_o/miss_count_o are tied to zero.
// rstn is asynchronous and active-high.
module lru_cache_nway #(
    parameter int TAGS_WIDTH  = 48,
    parameter int LINE_WIDTH  = 512,
    parameter int CACHE_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   flush_i,
    lru_cache_nway_if.slave        bus,
    output logic [31:0]            hit_count_o,
    output logic [31:0]            miss_count_o
);
    localparam int IDX_W = $clog2(CACHE_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_MEM_REQ,
        ST_MEM_WAIT,
        ST_RESP
    } state_t;

    state_t                 state_q, state_d;
    logic [TAGS_WIDTH-1:0]  req_tag_q;
    logic [LINE_WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic                   rsp_user_q, rsp_user_d;
    logic [IDX_W-1:0]       line_q, line_d;
    logic [CACHE_DEPTH-1:0] valid_q, valid_d;
    logic [IDX_W-1:0]       order_q [CACHE_DEPTH];
    logic [IDX_W-1:0]       order_d [CACHE_DEPTH];
    logic                   flush_pend_q, flush_pend_d;
    logic                   rdy_q, rdy_d;

    logic [TAGS_WIDTH-1:0]  tag_q  [CACHE_DEPTH];
    logic [LINE_WIDTH-1:0]  data_q [CACHE_DEPTH];

    logic                   req_hs, rsp_hs, mem_req_hs, mem_rsp_hs;
    logic                   apply_flush;
    logic                   fill_we;
    logic                   hit;
    logic [IDX_W-1:0]       hit_idx;
    logic [IDX_W-1:0]       victim;
    logic                   victim_found;
    logic [IDX_W-1:0]       mru_pos;

    assign req_hs     = bus.req_tvalid & bus.req_tready;
    assign rsp_hs     = bus.rsp_tvalid & bus.rsp_tready;
    assign mem_req_hs = bus.mem_req_tvalid & bus.mem_req_tready;
    assign mem_rsp_hs = bus.mem_rsp_tvalid & bus.mem_rsp_tready;

    // A flush seen outside IDLE is held until the FSM is back in IDLE.
    assign apply_flush = (state_q == ST_IDLE) & (flush_i | flush_pend_q);
    assign fill_we     = (state_q == ST_MEM_WAIT) & mem_rsp_hs;

    // rdy_q is registered so req_tready is 0 during reset; a same-cycle
    // flush still masks it combinationally.
    assign bus.req_tready     = rdy_q & ~flush_i;
    assign bus.rsp_tvalid     = (state_q == ST_RESP);
    assign bus.rsp_tdata      = rsp_data_q;
    assign bus.rsp_tuser      = rsp_user_q;
    assign bus.mem_req_tvalid = (state_q == ST_MEM_REQ);
    assign bus.mem_req_tdata  = req_tag_q;
    assign bus.mem_rsp_tready = (state_q == ST_MEM_WAIT);

    // Tag compare of the registered request against every valid line.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < CACHE_DEPTH; i++) begin
            if (valid_q[i] && (tag_q[i] == req_tag_q)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // Victim: first invalid line scanning from LRU towards MRU, else the LRU line.
    always_comb begin
        victim       = order_q[CACHE_DEPTH-1];
        victim_found = 1'b0;
        for (int unsigned j = 0; j < CACHE_DEPTH; j++) begin
            if (!victim_found && !valid_q[order_q[CACHE_DEPTH-1-j]]) begin
                victim       = order_q[CACHE_DEPTH-1-j];
                victim_found = 1'b1;
            end
        end
    end

    // Position of the served line inside the recency list.
    always_comb begin
        mru_pos = '0;
        for (int unsigned i = 0; i < CACHE_DEPTH; i++) begin
            if (order_q[i] == line_q) begin
                mru_pos = IDX_W'(i);
            end
        end
    end

    // Recency update: served line to the front, entries above it shift down.
    always_comb begin
        for (int unsigned i = 0; i < CACHE_DEPTH; i++) begin
            order_d[i] = order_q[i];
        end
        if ((state_q == ST_RESP) && rsp_hs) begin
            order_d[0] = line_q;
            for (int unsigned i = 1; i < CACHE_DEPTH; i++) begin
                if (IDX_W'(i) <= mru_pos) begin
                    order_d[i] = order_q[i-1];
                end
            end
        end
    end

    // FSM next state, response capture, valid bits and pending flush.
    always_comb begin
        state_d      = state_q;
        rsp_data_d   = rsp_data_q;
        rsp_user_d   = rsp_user_q;
        line_d       = line_q;
        valid_d      = valid_q;
        flush_pend_d = flush_pend_q;

        unique case (state_q)
            ST_IDLE: begin
                if (apply_flush) begin
                    valid_d = '0;
                end else if (req_hs) begin
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (hit) begin
                    rsp_data_d = data_q[hit_idx];
                    rsp_user_d = 1'b1;
                    line_d     = hit_idx;
                    state_d    = ST_RESP;
                end else begin
                    state_d    = ST_MEM_REQ;
                end
            end
            ST_MEM_REQ: begin
                if (mem_req_hs) begin
                    state_d = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_rsp_hs) begin
                    valid_d[victim] = 1'b1;
                    rsp_data_d      = bus.mem_rsp_tdata;
                    rsp_user_d      = 1'b0;
                    line_d          = victim;
                    state_d         = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (apply_flush) begin
            flush_pend_d = 1'b0;
        end else if (flush_i) begin
            flush_pend_d = 1'b1;
        end

        rdy_d = (state_d == ST_IDLE) && !flush_pend_d;
    end

    // Control state, recency list and valid bits with asynchronous reset.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q      <= ST_IDLE;
            req_tag_q    <= '0;
            rsp_data_q   <= '0;
            rsp_user_q   <= 1'b0;
            line_q       <= '0;
            valid_q      <= '0;
            flush_pend_q <= 1'b0;
            rdy_q        <= 1'b0;
            for (int unsigned i = 0; i < CACHE_DEPTH; i++) begin
                order_q[i] <= IDX_W'(i);
            end
        end else begin
            state_q      <= state_d;
            rsp_data_q   <= rsp_data_d;
            rsp_user_q   <= rsp_user_d;
            line_q       <= line_d;
            valid_q      <= valid_d;
            flush_pend_q <= flush_pend_d;
            rdy_q        <= rdy_d;
            for (int unsigned i = 0; i < CACHE_DEPTH; i++) begin
                order_q[i] <= order_d[i];
            end
            if (req_hs) begin
                req_tag_q <= bus.req_tdata;
            end
        end
    end

    // Tag/data storage; contents are qualified by valid_q so no reset needed.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[victim]  <= req_tag_q;
            data_q[victim] <= bus.mem_rsp_tdata;
        end
    end

`ifdef LRU_CACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    // Count served responses by hit/fill, wrapping at 32 bits.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (rsp_hs) begin
            if (rsp_user_q) begin
                hit_cnt_q  <= hit_cnt_q + 32'd1;
            end else begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
`else
    assign hit_count_o  = '0;
    assign miss_count_o = '0;
`endif

endmodule

// File: tb/tb_lru_cache_nway.sv
// Randomized self-checking bench for lru_cache_nway against a queue-based
// LRU reference model.
module tb_lru_cache_nway;
    localparam int TW = 48;
    localparam int LW = 512;
    localparam int D  = 8;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush_i;
    logic [31:0] hit_count, miss_count;

    lru_cache_nway_if #(.TAGS_WIDTH(TW), .LINE_WIDTH(LW)) bus ();

    lru_cache_nway #(
        .TAGS_WIDTH (TW),
        .LINE_WIDTH (LW),
        .CACHE_DEPTH(D)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .flush_i     (flush_i),
        .bus         (bus),
        .hit_count_o (hit_count),
        .miss_count_o(miss_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: lines with valid/tag/data, recency as a queue (MRU first).
    logic          m_valid [D];
    logic [TW-1:0] m_tag   [D];
    logic [LW-1:0] m_data  [D];
    int            m_order [$];
    int unsigned   m_hits, m_miss;

    task automatic check(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] mem_line(input logic [TW-1:0] t);
        if (t == 48'h100) return {64{8'hA5}};
        return {8{t, 16'h5A3C}};
    endfunction

    task automatic model_reset();
        m_order = {};
        for (int i = 0; i < D; i++) begin
            m_valid[i] = 1'b0;
            m_order.push_back(i);
        end
        m_hits = 0;
        m_miss = 0;
    endtask

    task automatic model_flush();
        for (int i = 0; i < D; i++) m_valid[i] = 1'b0;
    endtask

    task automatic check_counters(input string name);
`ifdef LRU_CACHE_STATS_EN
        check({name, "_hits"}, LW'(hit_count), LW'(m_hits));
        check({name, "_miss"}, LW'(miss_count), LW'(m_miss));
`else
        check({name, "_hits0"}, LW'(hit_count), '0);
        check({name, "_miss0"}, LW'(miss_count), '0);
`endif
    endtask

    task automatic check_all_zero(input string p);
        check({p, "_req_tready"}, LW'(bus.req_tready), '0);
        check({p, "_rsp_tvalid"}, LW'(bus.rsp_tvalid), '0);
        check({p, "_rsp_tdata"}, bus.rsp_tdata, '0);
        check({p, "_rsp_tuser"}, LW'(bus.rsp_tuser), '0);
        check({p, "_mreq_tvalid"}, LW'(bus.mem_req_tvalid), '0);
        check({p, "_mreq_tdata"}, LW'(bus.mem_req_tdata), '0);
        check({p, "_mrsp_tready"}, LW'(bus.mem_rsp_tready), '0);
        check({p, "_hit_cnt"}, LW'(hit_count), '0);
        check({p, "_miss_cnt"}, LW'(miss_count), '0);
    endtask

    // One complete request; returns once the response has been accepted.
    task automatic xact(input logic [TW-1:0] t, input int hold,
                        input bit flush_wait, input bit flush_req);
        int            hidx, v, cyc, pos;
        bit            found;
        logic [LW-1:0] exp_data;

        @(negedge clk);
        bus.req_tvalid = 1'b1;
        bus.req_tdata  = t;
        if (flush_req) begin
            flush_i = 1'b1;
            #1;
            check("flush_wins_ready", LW'(bus.req_tready), '0);
            @(negedge clk);
            flush_i = 1'b0;
            model_flush();
        end
        #1;
        cyc = 0;
        while (!bus.req_tready && cyc < 50) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        if (!bus.req_tready) begin
            check("req_timeout", '0, LW'(1));
            bus.req_tvalid = 1'b0;
            return;
        end

        hidx = -1;
        for (int i = 0; i < D; i++) if (m_valid[i] && m_tag[i] == t) hidx = i;

        @(negedge clk);
        bus.req_tvalid = 1'b0;
        check("lookup_no_rsp", LW'(bus.rsp_tvalid), '0);
        @(negedge clk);

        if (hidx >= 0) begin
            check("hit_lat_rsp_tvalid", LW'(bus.rsp_tvalid), LW'(1));
            check("hit_no_mem_req", LW'(bus.mem_req_tvalid), '0);
            exp_data = m_data[hidx];
            v        = hidx;
        end else begin
            check("miss_mem_req_tvalid", LW'(bus.mem_req_tvalid), LW'(1));
            check("miss_mem_req_tdata", LW'(bus.mem_req_tdata), LW'(t));
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                check("mem_req_held", LW'(bus.mem_req_tvalid), LW'(1));
            end
            bus.mem_req_tready = 1'b1;
            @(negedge clk);
            bus.mem_req_tready = 1'b0;
            check("mem_wait_tready", LW'(bus.mem_rsp_tready), LW'(1));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            bus.mem_rsp_tvalid = 1'b1;
            bus.mem_rsp_tdata  = mem_line(t);
            if (flush_wait) flush_i = 1'b1;
            @(negedge clk);
            bus.mem_rsp_tvalid = 1'b0;
            bus.mem_rsp_tdata  = '0;
            flush_i            = 1'b0;
            check("fill_lat_rsp_tvalid", LW'(bus.rsp_tvalid), LW'(1));
            exp_data = mem_line(t);
            v     = m_order[$];
            found = 1'b0;
            for (int k = D - 1; k >= 0; k--) begin
                if (!found && !m_valid[m_order[k]]) begin
                    v     = m_order[k];
                    found = 1'b1;
                end
            end
            m_valid[v] = 1'b1;
            m_tag[v]   = t;
            m_data[v]  = exp_data;
        end

        for (int h = 0; h < hold; h++) begin
            check("hold_req_tready", LW'(bus.req_tready), '0);
            check("hold_rsp_tvalid", LW'(bus.rsp_tvalid), LW'(1));
            @(negedge clk);
        end
        check("rsp_tdata", bus.rsp_tdata, exp_data);
        check("rsp_tuser", LW'(bus.rsp_tuser), LW'(hidx >= 0));
        bus.rsp_tready = 1'b1;
        @(negedge clk);
        bus.rsp_tready = 1'b0;

        pos = 0;
        for (int k = 0; k < m_order.size(); k++) if (m_order[k] == v) pos = k;
        m_order.delete(pos);
        m_order.push_front(v);
        if (hidx >= 0) m_hits++;
        else           m_miss++;
        if (flush_wait && hidx < 0) model_flush();
        check_counters("cnt");
    endtask

    initial begin
        bus.req_tvalid     = 1'b0;
        bus.req_tdata      = '0;
        bus.rsp_tready     = 1'b0;
        bus.mem_req_tready = 1'b0;
        bus.mem_rsp_tvalid = 1'b0;
        bus.mem_rsp_tdata  = '0;
        flush_i            = 1'b0;
        rstn               = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rstn = 1'b0;

        // Basic miss then hit.
        xact(48'h100, 0, 1'b0, 1'b0);
        xact(48'h100, 0, 1'b0, 1'b0);

        // Fill 1..8, touch 1, then 9 evicts the LRU line (tag 2).
        for (int i = 1; i <= 8; i++) xact(TW'(i), 0, 1'b0, 1'b0);
        xact(48'd1, 0, 1'b0, 1'b0);
        xact(48'd9, 0, 1'b0, 1'b0);
        xact(48'd1, 0, 1'b0, 1'b0);
        xact(48'd2, 0, 1'b0, 1'b0);

        // Response back-pressure on a hit.
        xact(48'd1, 10, 1'b0, 1'b0);

        // Flush during MEM_WAIT, then everything misses.
        xact(48'h55, 0, 1'b1, 1'b0);
        xact(48'h55, 0, 1'b0, 1'b0);
        xact(48'd1, 0, 1'b0, 1'b0);

        // Flush coinciding with a request in IDLE.
        xact(48'd1, 0, 1'b0, 1'b1);

        // Randomized traffic over a small tag pool.
        for (int n = 0; n < 250; n++) begin
            xact(TW'($urandom_range(1, 12)), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
        end

        // Reset asserted while in MEM_REQ.
        xact(48'h100, 0, 1'b0, 1'b0);
        @(negedge clk);
        bus.req_tvalid = 1'b1;
        bus.req_tdata  = 48'h777;
        #1;
        check("rst_pre_ready", LW'(bus.req_tready), LW'(1));
        @(negedge clk);
        bus.req_tvalid = 1'b0;
        @(negedge clk);
        check("rst_in_mem_req", LW'(bus.mem_req_tvalid), LW'(1));
        rstn = 1'b1;
        @(negedge clk);
        check_all_zero("midreset");
        bus.mem_rsp_tvalid = 1'b1;
        bus.mem_rsp_tdata  = mem_line(48'h777);
        rstn = 1'b0;
        model_reset();
        @(negedge clk);
        check("late_mrsp_tready", LW'(bus.mem_rsp_tready), '0);
        check("late_mrsp_rsp", LW'(bus.rsp_tvalid), '0);
        bus.mem_rsp_tvalid = 1'b0;
        bus.mem_rsp_tdata  = '0;
        xact(48'h100, 0, 1'b0, 1'b0);

        // Statistics: 3 misses and 5 hits from a clean reset.
        rstn = 1'b1;
        @(negedge clk);
        rstn = 1'b0;
        model_reset();
        xact(48'hA01, 0, 1'b0, 1'b0);
        xact(48'hA02, 0, 1'b0, 1'b0);
        xact(48'hA03, 0, 1'b0, 1'b0);
        xact(48'hA01, 0, 1'b0, 1'b0);
        xact(48'hA01, 0, 1'b0, 1'b0);
        xact(48'hA02, 0, 1'b0, 1'b0);
        xact(48'hA02, 0, 1'b0, 1'b0);
        xact(48'hA03, 0, 1'b0, 1'b0);
`ifdef LRU_CACHE_STATS_EN
        check("stats_hit_count", LW'(hit_count), LW'(5));
        check("stats_miss_count", LW'(miss_count), LW'(3));
`else
        check("stats_hit_off", LW'(hit_count), '0);
        check("stats_miss_off", LW'(miss_count), '0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Overall time bound so the run always ends.
    initial begin
        #2000000;
        failures++;
        $display("FAIL global_timeout got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
